// File: rtl/axi_lite_cmd_master.sv
// rtl/axi_lite_cmd_master.sv - single-outstanding AXI-Lite initiator for register commands
// Turns one command into an AW/W/B or AR/R sequence and reports it on a one-cycle strobe.
module axi_lite_cmd_master #(
  parameter int AXI_LITE_ADDR_WIDTH = 8,
  parameter int TIMEOUT_CYCLES      = 1024
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           cmd_valid,
  output logic                           cmd_ready,
  input  logic                           cmd_write,
  input  logic [AXI_LITE_ADDR_WIDTH-1:0] cmd_addr,
  input  logic [31:0]                    cmd_wdata,
  output logic                           rsp_valid,
  output logic                           rsp_write,
  output logic [31:0]                    rsp_data,
  output logic [1:0]                     rsp_resp,
  output logic                           timeout,
  output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_awaddr,
  output logic                           m_axi_lite_awvalid,
  input  logic                           m_axi_lite_awready,
  output logic [31:0]                    m_axi_lite_wdata,
  output logic                           m_axi_lite_wvalid,
  input  logic                           m_axi_lite_wready,
  input  logic [1:0]                     m_axi_lite_bresp,
  input  logic                           m_axi_lite_bvalid,
  output logic                           m_axi_lite_bready,
  output logic [AXI_LITE_ADDR_WIDTH-1:0] m_axi_lite_araddr,
  output logic                           m_axi_lite_arvalid,
  input  logic                           m_axi_lite_arready,
  input  logic [31:0]                    m_axi_lite_rdata,
  input  logic [1:0]                     m_axi_lite_rresp,
  input  logic                           m_axi_lite_rvalid,
  output logic                           m_axi_lite_rready
);

  typedef enum logic [2:0] {
    S_IDLE, S_WR_AW_W, S_WR_W, S_WR_AW, S_WR_B, S_RD_AR, S_RD_R, S_RESP
  } state_t;

  localparam logic [15:0] WDOG_LAST = 16'(TIMEOUT_CYCLES - 1);

  state_t                           state_q, state_d;
  logic [AXI_LITE_ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [31:0]                      wdata_q, wdata_d;
  logic                             write_q, write_d;
  logic [31:0]                      rsp_data_q, rsp_data_d;
  logic [1:0]                       rsp_resp_q, rsp_resp_d;
  logic [15:0]                      wdog_q, wdog_d;
  logic                             timeout_q, timeout_d;
  logic                             aw_hs, w_hs;

  assign aw_hs = m_axi_lite_awready;
  assign w_hs  = m_axi_lite_wready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    write_d    = write_q;
    rsp_data_d = rsp_data_q;
    rsp_resp_d = rsp_resp_q;
    wdog_d     = wdog_q;
    timeout_d  = timeout_q;

    // The watchdog only flags slow slaves; it never aborts the transaction.
    if (state_q != S_IDLE && state_q != S_RESP) begin
      if (wdog_q != 16'hFFFF) wdog_d = wdog_q + 16'd1;
      if (wdog_q == WDOG_LAST) timeout_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          wdata_d   = cmd_wdata;
          write_d   = cmd_write;
          wdog_d    = 16'd0;
          timeout_d = 1'b0;
          state_d   = cmd_write ? S_WR_AW_W : S_RD_AR;
        end
      end
      S_WR_AW_W: begin
        if (aw_hs && w_hs) state_d = S_WR_B;
        else if (aw_hs)    state_d = S_WR_W;
        else if (w_hs)     state_d = S_WR_AW;
      end
      S_WR_W:  if (w_hs)  state_d = S_WR_B;
      S_WR_AW: if (aw_hs) state_d = S_WR_B;
      S_WR_B: begin
        if (m_axi_lite_bvalid) begin
          rsp_resp_d = m_axi_lite_bresp;
          rsp_data_d = 32'd0;
          state_d    = S_RESP;
        end
      end
      S_RD_AR: if (m_axi_lite_arready) state_d = S_RD_R;
      S_RD_R: begin
        if (m_axi_lite_rvalid) begin
          rsp_data_d = m_axi_lite_rdata;
          rsp_resp_d = m_axi_lite_rresp;
          state_d    = S_RESP;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= 32'd0;
      write_q    <= 1'b0;
      rsp_data_q <= 32'd0;
      rsp_resp_q <= 2'd0;
      wdog_q     <= 16'd0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      write_q    <= write_d;
      rsp_data_q <= rsp_data_d;
      rsp_resp_q <= rsp_resp_d;
      wdog_q     <= wdog_d;
      timeout_q  <= timeout_d;
    end
  end

  assign cmd_ready          = (state_q == S_IDLE);
  assign rsp_valid          = (state_q == S_RESP);
  assign rsp_write          = write_q;
  assign rsp_data           = rsp_data_q;
  assign rsp_resp           = rsp_resp_q;
  assign timeout            = timeout_q;
  assign m_axi_lite_awaddr  = addr_q;
  assign m_axi_lite_awvalid = (state_q == S_WR_AW_W) || (state_q == S_WR_AW);
  assign m_axi_lite_wdata   = wdata_q;
  assign m_axi_lite_wvalid  = (state_q == S_WR_AW_W) || (state_q == S_WR_W);
  assign m_axi_lite_bready  = (state_q == S_WR_B);
  assign m_axi_lite_araddr  = addr_q;
  assign m_axi_lite_arvalid = (state_q == S_RD_AR);
  assign m_axi_lite_rready  = (state_q == S_RD_R);

endmodule

// File: tb/tb_axi_lite_cmd_master.sv
// tb/tb_axi_lite_cmd_master.sv - scoreboard bench for axi_lite_cmd_master against a delay-programmable slave
module tb_axi_lite_cmd_master;

  logic        aclk, aresetn;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid, rsp_write, timeout;
  logic [31:0] rsp_data;
  logic [1:0]  rsp_resp;
  logic [7:0]  awaddr, araddr;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [31:0] wdata, rdata;
  logic [1:0]  bresp, rresp;

  axi_lite_cmd_master #(.AXI_LITE_ADDR_WIDTH(8), .TIMEOUT_CYCLES(8)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_data(rsp_data),
    .rsp_resp(rsp_resp), .timeout(timeout),
    .m_axi_lite_awaddr(awaddr), .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
    .m_axi_lite_wdata(wdata), .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready),
    .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
    .m_axi_lite_araddr(araddr), .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
    .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp), .m_axi_lite_rvalid(rvalid),
    .m_axi_lite_rready(rready)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct packed {
    logic        w;
    logic [31:0] d;
    logic [1:0]  r;
  } exp_t;
  exp_t exp_q[$];

  int          aw_delay = 0, w_delay = 0, b_delay = 0, ar_delay = 0, r_delay = 0;
  logic [1:0]  b_resp_cfg = 2'b00, r_resp_cfg = 2'b00;
  bit          r_force = 0;
  logic [31:0] r_force_data = 32'd0;
  int          aw_hs_cyc = 0, w_hs_cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  initial begin
    aclk = 1'b0;
    forever #5 aclk = ~aclk;
  end

  always @(posedge aclk) cyc <= cyc + 1;

  // Slave model: ready/response decisions are made on the falling edge so the
  // handshake on the following rising edge is known in advance.
  initial begin
    logic [31:0] mem [0:255];
    int aw_wait, w_wait, b_wait, ar_wait, r_wait, aw_hs, w_hs;
    bit aw_taken, w_taken, ar_taken, rsp_due;
    logic [7:0]  aw_addr0, aw_cap, ar_cap;
    logic [31:0] w_data0, w_cap;
    for (int i = 0; i < 256; i++) mem[i] = 32'd0;
    awready = 0; wready = 0; bvalid = 0; bresp = 0;
    arready = 0; rvalid = 0; rdata = 0; rresp = 0;
    aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0; aw_hs = 0; w_hs = 0;
    aw_taken = 0; w_taken = 0; ar_taken = 0; rsp_due = 0;
    aw_addr0 = 0; aw_cap = 0; ar_cap = 0; w_data0 = 0; w_cap = 0;
    forever begin
      @(negedge aclk);
      if (!aresetn) begin
        awready = 0; wready = 0; bvalid = 0; arready = 0; rvalid = 0;
        aw_wait = 0; w_wait = 0; b_wait = 0; ar_wait = 0; r_wait = 0; aw_hs = 0; w_hs = 0;
        aw_taken = 0; w_taken = 0; ar_taken = 0; rsp_due = 0;
      end else begin
        if (rsp_due) chk("rsp_latency", 32'(rsp_valid), 32'd1);
        rsp_due = 0;
        awready = 0;
        if (aw_taken) chk("aw_drop", 32'(awvalid), 32'd0);
        else if (awvalid || aw_wait > 0) begin
          chk("aw_held", 32'(awvalid), 32'd1);
          if (aw_wait == 0) aw_addr0 = awaddr;
          else chk("aw_stable", 32'(awaddr), 32'(aw_addr0));
          if (aw_wait >= aw_delay) begin
            awready = 1; aw_taken = 1; aw_hs++; aw_cap = awaddr; aw_hs_cyc = cyc;
          end else aw_wait++;
        end
        wready = 0;
        if (w_taken) chk("w_drop", 32'(wvalid), 32'd0);
        else if (wvalid || w_wait > 0) begin
          chk("w_held", 32'(wvalid), 32'd1);
          if (w_wait == 0) w_data0 = wdata;
          else chk("w_stable", wdata, w_data0);
          if (w_wait >= w_delay) begin
            wready = 1; w_taken = 1; w_hs++; w_cap = wdata; w_hs_cyc = cyc;
          end else w_wait++;
        end
        bvalid = 0;
        if (aw_taken && w_taken && bready) begin
          if (b_wait >= b_delay) begin
            bvalid = 1; bresp = b_resp_cfg; rsp_due = 1;
            mem[aw_cap] = w_cap;
            chk("aw_count", 32'(aw_hs), 32'd1);
            chk("w_count", 32'(w_hs), 32'd1);
            aw_taken = 0; w_taken = 0; aw_wait = 0; w_wait = 0; b_wait = 0; aw_hs = 0; w_hs = 0;
          end else b_wait++;
        end
        arready = 0;
        if (ar_taken) chk("ar_drop", 32'(arvalid), 32'd0);
        else if (arvalid) begin
          if (ar_wait >= ar_delay) begin
            arready = 1; ar_taken = 1; ar_cap = araddr;
          end else ar_wait++;
        end
        rvalid = 0;
        rdata  = 32'hBAD0_BAD0;
        if (ar_taken && rready) begin
          if (r_wait >= r_delay) begin
            rvalid = 1; rresp = r_resp_cfg; rsp_due = 1;
            rdata  = r_force ? r_force_data : mem[ar_cap];
            ar_taken = 0; ar_wait = 0; r_wait = 0;
          end else r_wait++;
        end
      end
    end
  end

  // Monitor: every response strobe is matched against the oldest expectation.
  initial begin
    bit after_rsp;
    exp_t e;
    after_rsp = 0;
    forever begin
      @(negedge aclk);
      if (after_rsp) chk("cmd_ready_after_rsp", 32'(cmd_ready), 32'd1);
      after_rsp = 0;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("rsp_write", 32'(rsp_write), 32'(e.w));
          chk("rsp_data", rsp_data, e.d);
          chk("rsp_resp", 32'(rsp_resp), 32'(e.r));
          chk("cmd_ready_in_rsp", 32'(cmd_ready), 32'd0);
          after_rsp = 1;
        end
      end
    end
  end

  task automatic issue(input logic w, input logic [7:0] a, input logic [31:0] d,
                       input logic [31:0] ed, input logic [1:0] er, input bit push);
    int n;
    n = 0;
    @(negedge aclk);
    cmd_valid = 1; cmd_write = w; cmd_addr = a; cmd_wdata = d;
    while (!cmd_ready && n < 100) begin
      @(negedge aclk);
      n++;
    end
    chk("accept_wait", 32'(cmd_ready), 32'd1);
    if (push) exp_q.push_back('{w: w, d: ed, r: er});
    @(posedge aclk);
    #1;
    cmd_valid = 0;
    chk("busy_after_accept", 32'(cmd_ready), 32'd0);
    chk("timeout_clear_on_accept", 32'(timeout), 32'd0);
    if (w) begin
      chk("awvalid_n1", 32'(awvalid), 32'd1);
      chk("wvalid_n1", 32'(wvalid), 32'd1);
    end else begin
      chk("arvalid_n1", 32'(arvalid), 32'd1);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !cmd_ready) && n < 200) begin
      @(negedge aclk);
      n++;
    end
    chk("completion_wait", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected completion");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int n;
    aresetn = 0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_wdata = 0;
    repeat (3) @(negedge aclk);
    aresetn = 1;
    @(negedge aclk);
    chk("rst_awvalid", 32'(awvalid), 32'd0);
    chk("rst_wvalid", 32'(wvalid), 32'd0);
    chk("rst_arvalid", 32'(arvalid), 32'd0);
    chk("rst_bready", 32'(bready), 32'd0);
    chk("rst_rready", 32'(rready), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_rsp_data", rsp_data, 32'd0);
    chk("rst_rsp_resp", 32'(rsp_resp), 32'd0);

    // Colour-generator frame register write, then read back.
    issue(1'b1, 8'h00, 32'h0000_0012, 32'd0, 2'b00, 1);
    wait_idle();
    chk("aw_w_same_edge", 32'(aw_hs_cyc), 32'(w_hs_cyc));
    issue(1'b0, 8'h00, 32'hFFFF_FFFF, 32'h0000_0012, 2'b00, 1);
    wait_idle();

    // W three cycles ahead of AW.
    aw_delay = 3; w_delay = 0;
    issue(1'b1, 8'h04, 32'hA5A5_0004, 32'd0, 2'b00, 1);
    wait_idle();
    chk("w_before_aw", 32'(aw_hs_cyc - w_hs_cyc), 32'd3);
    // AW three cycles ahead of W, slave answers SLVERR.
    aw_delay = 0; w_delay = 3; b_resp_cfg = 2'b10;
    issue(1'b1, 8'h0C, 32'h0BAD_000C, 32'd0, 2'b10, 1);
    wait_idle();
    chk("aw_before_w", 32'(w_hs_cyc - aw_hs_cyc), 32'd3);
    w_delay = 0; b_resp_cfg = 2'b00;
    issue(1'b0, 8'h04, 32'd0, 32'hA5A5_0004, 2'b00, 1);
    wait_idle();

    // Delayed read with forced data and SLVERR.
    ar_delay = 2; r_delay = 5; r_force = 1; r_force_data = 32'hDEAD_BEEF; r_resp_cfg = 2'b10;
    issue(1'b0, 8'h1C, 32'd0, 32'hDEAD_BEEF, 2'b10, 1);
    wait_idle();
    ar_delay = 0; r_delay = 0; r_force = 0; r_resp_cfg = 2'b00;

    // Watchdog: B withheld for 20 cycles.
    b_delay = 20;
    issue(1'b1, 8'h08, 32'h0000_0808, 32'd0, 2'b00, 1);
    repeat (8) @(negedge aclk);
    chk("timeout_not_yet", 32'(timeout), 32'd0);
    @(negedge aclk);
    chk("timeout_rise", 32'(timeout), 32'd1);
    chk("bready_held", 32'(bready), 32'd1);
    repeat (4) @(negedge aclk);
    chk("bready_still_held", 32'(bready), 32'd1);
    wait_idle();
    chk("timeout_sticky", 32'(timeout), 32'd1);
    b_delay = 0;
    issue(1'b0, 8'h08, 32'd0, 32'h0000_0808, 2'b00, 1);
    wait_idle();
    chk("timeout_after_clear", 32'(timeout), 32'd0);

    // Reset while waiting for R: the read is dropped without a response.
    r_delay = 10;
    issue(1'b0, 8'h0C, 32'd0, 32'd0, 2'b00, 0);
    n = 0;
    while (!rready && n < 20) begin
      @(negedge aclk);
      n++;
    end
    chk("reached_rd_r", 32'(rready), 32'd1);
    #2;
    aresetn = 0;
    #1;
    chk("async_rready", 32'(rready), 32'd0);
    chk("async_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("async_rsp_valid", 32'(rsp_valid), 32'd0);
    repeat (2) @(negedge aclk);
    aresetn = 1;
    r_delay = 0;
    issue(1'b0, 8'h0C, 32'd0, 32'h0BAD_000C, 2'b00, 1);
    wait_idle();
    issue(1'b1, 8'h10, 32'h1234_5678, 32'd0, 2'b00, 1);
    wait_idle();
    issue(1'b0, 8'h10, 32'd0, 32'h1234_5678, 2'b00, 1);
    wait_idle();
    repeat (3) @(negedge aclk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
